precision_dispatch_ctrl: RTL and testbench

Controller that sequences one precision-assignment pass and then dispatches every token to the compute lane matching its assigned precision. It launches the precision assigner, waits for its completion, latches the L 4-bit codes, and issues token indices one at a time over per-lane valid/ready handshakes to the int4, int8 and fp16 engines. It sits between the attention-score stage and the mixed-precision compute lanes, and reports per-lane token counts for downstream buffer sizing.

---
 rtl/precision_dispatch_ctrl.sv | 128 ++++++++++++
 tb/tb_precision_dispatch_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/precision_dispatch_ctrl.sv
// Runs one precision-assignment pass, then offers each token index to the
// int4 / int8 / fp16 lane selected by its latched 4-bit code.
module precision_dispatch_ctrl #(
  parameter  int L     = 8,
  localparam int IDX_W = $clog2(L),
  localparam int CNT_W = $clog2(L + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               assign_start,
  input  logic               assign_done,
  input  logic [4*L-1:0]     prec_in,
  output logic [2:0]         lane_valid,
  input  logic [2:0]         lane_ready,
  output logic [IDX_W-1:0]   lane_tok,
  output logic [CNT_W-1:0]   cnt_int4,
  output logic [CNT_W-1:0]   cnt_int8,
  output logic [CNT_W-1:0]   cnt_fp16,
  output logic [2:0]         dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LAUNCH   = 3'd1,
    S_WAIT     = 3'd2,
    S_DISPATCH = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        tok_q, tok_d;
  logic [L-1:0][3:0]       codes_q, codes_d;
  logic [CNT_W-1:0]        c4_q, c4_d, c8_q, c8_d, c16_q, c16_d;
  logic                    busy_q, busy_d, done_q, done_d, astart_q, astart_d;
  logic [2:0]              valid_q, valid_d;
  logic [IDX_W-1:0]        ltok_q, ltok_d;
  logic                    hs;

  function automatic logic [2:0] lane_sel(input logic [3:0] code);
    if (code == 4'd0)      lane_sel = 3'b001;
    else if (code == 4'd1) lane_sel = 3'b010;
    else                   lane_sel = 3'b100;
  endfunction

  // Handshake: a token moves when the single valid lane also has ready high
  // on the same rising edge; valid and lane_tok never drop or change before that.
  always_comb begin
    state_d = state_q;
    tok_d   = tok_q;
    codes_d = codes_q;
    c4_d    = c4_q;
    c8_d    = c8_q;
    c16_d   = c16_q;
    hs      = |(valid_q & lane_ready);
    case (state_q)
      S_IDLE:   if (start) state_d = S_LAUNCH;
      S_LAUNCH: begin
        tok_d   = '0;
        c4_d    = '0;
        c8_d    = '0;
        c16_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: if (assign_done) begin
        codes_d = prec_in;
        state_d = S_DISPATCH;
      end
      S_DISPATCH: if (hs) begin
        if (valid_q[0]) c4_d  = c4_q + CNT_W'(1);
        if (valid_q[1]) c8_d  = c8_q + CNT_W'(1);
        if (valid_q[2]) c16_d = c16_q + CNT_W'(1);
        if (tok_q == IDX_W'(L - 1)) state_d = S_DONE;
        else                        tok_d   = tok_q + IDX_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered: decode them from the next-state values.
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    astart_d = (state_d == S_LAUNCH);
    valid_d  = (state_d == S_DISPATCH) ? lane_sel(codes_d[tok_d]) : 3'b000;
    ltok_d   = (state_d == S_DISPATCH) ? tok_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tok_q    <= '0;
      codes_q  <= '0;
      c4_q     <= '0;
      c8_q     <= '0;
      c16_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      astart_q <= 1'b0;
      valid_q  <= 3'b000;
      ltok_q   <= '0;
    end else begin
      state_q  <= state_d;
      tok_q    <= tok_d;
      codes_q  <= codes_d;
      c4_q     <= c4_d;
      c8_q     <= c8_d;
      c16_q    <= c16_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      astart_q <= astart_d;
      valid_q  <= valid_d;
      ltok_q   <= ltok_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign assign_start = astart_q;
  assign lane_valid   = valid_q;
  assign lane_tok     = ltok_q;
  assign cnt_int4     = c4_q;
  assign cnt_int8     = c8_q;
  assign cnt_fp16     = c16_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_precision_dispatch_ctrl.sv
// Directed bench for precision_dispatch_ctrl: expected {lane, token} words are
// queued at launch and popped as each handshake is observed.
module tb_precision_dispatch_ctrl;
  localparam int L = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, assign_done;
  logic [4*L-1:0] prec_in;
  logic [2:0]   lane_ready;
  logic         busy, done, assign_start;
  logic [2:0]   lane_valid, lane_tok, dbg_state;
  logic [3:0]   cnt_int4, cnt_int8, cnt_fp16;

  precision_dispatch_ctrl #(.L(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .assign_start(assign_start), .assign_done(assign_done), .prec_in(prec_in),
    .lane_valid(lane_valid), .lane_ready(lane_ready), .lane_tok(lane_tok),
    .cnt_int4(cnt_int4), .cnt_int8(cnt_int8), .cnt_fp16(cnt_fp16),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  logic [5:0] exp_q[$];
  logic [3:0] codes[L];
  int n_cmp = 0, n_err = 0, n_launch = 0;
  int m4, m8, m16, cyc;

  always @(negedge clk) if (assign_start === 1'b1) n_launch++;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] lane_of(input logic [3:0] code);
    case (code)
      4'd0:    return 3'b001;
      4'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_astart"}, assign_start, 0);
    check({tag, "_valid"}, lane_valid, 0);
    check({tag, "_tok"}, lane_tok, 0);
    check({tag, "_cnts"}, {cnt_int4, cnt_int8, cnt_fp16}, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // Starts a pass; assign_done is returned 'delay' cycles after assign_start.
  task automatic launch(input int delay, input bit poke_wait, input bit early_done);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("launch_state", dbg_state, 1);
    check("launch_astart", assign_start, 1);
    check("launch_busy", busy, 1);
    m4 = 0; m8 = 0; m16 = 0;
    for (int t = 0; t < L; t++) begin
      prec_in[4*t +: 4] = codes[t];
      exp_q.push_back({lane_of(codes[t]), 3'(t)});
      if (codes[t] == 4'd0)      m4++;
      else if (codes[t] == 4'd1) m8++;
      else                       m16++;
    end
    if (early_done) assign_done = 1'b1;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      assign_done = 1'b0;
      start = (poke_wait && i == 0);
      check("wait_state", dbg_state, 2);
      check("wait_astart", assign_start, 0);
      check("wait_valid", lane_valid, 0);
    end
    start = 1'b0;
    assign_done = 1'b1;
    @(negedge clk);
    assign_done = 1'b0;
    prec_in = 32'($urandom);
  endtask

  task automatic drain(input int n_take, input int stall_tok, input int stall_n,
                       input int start_tok, output int cycles);
    int stalls = 0, taken = 0, guard = 0;
    bit poked = 0;
    logic [5:0] e;
    logic [2:0] r;
    cycles = 0;
    while (taken < n_take && exp_q.size() > 0 && guard < 100) begin
      guard++;
      e = exp_q[0];
      check("lane_valid", lane_valid, e[5:3]);
      check("lane_tok", lane_tok, e[2:0]);
      r = 3'($urandom_range(0, 7));
      start = (!poked && int'(e[2:0]) == start_tok);
      if (start) poked = 1;
      if (int'(e[2:0]) == stall_tok && stalls < stall_n) begin
        lane_ready = r & ~e[5:3];
        stalls++;
      end else begin
        lane_ready = r | e[5:3];
        void'(exp_q.pop_front());
        taken++;
      end
      cycles++;
      @(negedge clk);
    end
    start = 1'b0;
    lane_ready = 3'b000;
    if (guard >= 100) check("drain_timeout", guard, 0);
  endtask

  task automatic finish_pass(input int exp_launches, input bit poke_start);
    check("done_hi", done, 1);
    check("done_busy", busy, 1);
    check("done_state", dbg_state, 4);
    check("done_valid", lane_valid, 0);
    start = poke_start;
    @(negedge clk);
    start = 1'b0;
    check("post_done_lo", done, 0);
    check("post_busy_lo", busy, 0);
    check("post_state", dbg_state, 0);
    @(negedge clk);
    check("no_relaunch", assign_start, 0);
    check("idle_state", dbg_state, 0);
    check("cnt_int4", cnt_int4, m4);
    check("cnt_int8", cnt_int8, m8);
    check("cnt_fp16", cnt_fp16, m16);
    check("cnt_sum", cnt_int4 + cnt_int8 + cnt_fp16, L);
    check("launches", n_launch, exp_launches);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; assign_done = 1'b0; prec_in = '0; lane_ready = 3'b000;
    repeat (2) begin
      @(negedge clk);
      check_idle_zero("reset");
    end
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check_idle_zero("post_reset");

    // Basic pass, all lanes ready, start poked during DONE.
    codes = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    launch(5, 0, 0);
    drain(L, -1, 0, -1, cyc);
    check("basic_cycles", cyc, L);
    finish_pass(1, 1);

    // Back-pressure on fp16 while token 2 is offered.
    launch(5, 0, 0);
    drain(L, 2, 4, -1, cyc);
    check("bp_cycles", cyc, L + 4);
    finish_pass(2, 0);

    // Every code fp16; assign_done raised during LAUNCH is ignored.
    for (int t = 0; t < L; t++) codes[t] = 4'd15;
    launch(3, 0, 1);
    drain(L, -1, 0, -1, cyc);
    check("fp16_cycles", cyc, L);
    finish_pass(3, 0);

    // Random codes; start poked in WAIT_ASSIGN and in DISPATCH.
    for (int t = 0; t < L; t++) codes[t] = 4'($urandom_range(0, 15));
    codes[0] = 4'd0; codes[1] = 4'd1;
    launch(4, 1, 0);
    drain(L, -1, 0, 3, cyc);
    check("ign_cycles", cyc, L);
    finish_pass(4, 0);

    // Abort while token 4 is offered, then a clean full pass.
    codes = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    launch(2, 0, 0);
    drain(4, -1, 0, -1, cyc);
    check("abort_tok", lane_tok, 4);
    check("abort_valid", lane_valid, 3'b010);
    check("abort_done", done, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_zero("abort");
    exp_q.delete();
    @(negedge clk);
    check_idle_zero("abort_idle");
    launch(5, 0, 0);
    drain(L, -1, 0, -1, cyc);
    check("rerun_cycles", cyc, L);
    finish_pass(6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
